// File: rtl/key_ctrl_pkg.sv
// key_ctrl shared types: direction encoding, project
// defaults and the priority pick helper.
package key_ctrl_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    DOWN  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  localparam int KEY_DEBOUNCE_CYCLES = 16;
  localparam int ME_MOVE_DIV         = 1;

  // bit index == encoding; lowest index wins
  function automatic dir_t pick(input logic [3:0] v);
    dir_t d;
    d = UP;
    priority case (1'b1)
      v[0]:    d = UP;
      v[1]:    d = DOWN;
      v[2]:    d = LEFT;
      v[3]:    d = RIGHT;
      default: d = UP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/key_ctrl_debounce.sv
// key_debounce: sync + polarity + debounce of one button.
// Ports: clk_run, rst_n, key_i (raw) -> db_o, db_rise_o.
module key_debounce
  import key_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic clk_run,
  input  logic rst_n,
  input  logic key_i,
  output logic db_o,
  output logic db_rise_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          w_norm;
  logic [2:0]    r_sync;
  logic [DW-1:0] r_cnt;
  logic          r_db;
  logic          r_rise;

  // invert before the first flop so every stage
  // resets to "released"
  assign w_norm = (KEY_ACTIVE_LOW != 0) ? ~key_i : key_i;

  always_ff @(posedge clk_run or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_db   <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[1:0], w_norm};
      r_rise <= 1'b0;
      if (r_sync[2] == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_cnt  <= '0;
        r_db   <= r_sync[2];
        r_rise <= r_sync[2];
      end else begin
        r_cnt <= r_cnt + DW'(1);
      end
    end
  end

  assign db_o      = r_db;
  assign db_rise_o = r_rise;

endmodule

// File: rtl/key_ctrl.sv
// key_ctrl: debounced direction arbitration, move strobe,
// fire pulse. Out: direct_o, move_en_o, fire_o, any_key_o.
module key_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
  parameter int MOVE_DIV        = ME_MOVE_DIV,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic       clk_run,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       key_up_i,
  input  logic       key_down_i,
  input  logic       key_left_i,
  input  logic       key_right_i,
  input  logic       key_fire_i,
  output logic [1:0] direct_o,
  output logic       move_en_o,
  output logic       fire_o,
  output logic       any_key_o
);

  localparam int CW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(MOVE_DIV - 1);

  logic [3:0]    w_keys;
  logic [3:0]    w_db;
  logic [3:0]    w_rise;
  logic          w_fdb;
  logic          w_frise;

  dir_t          r_dir;
  logic          r_act;
  logic          r_run;
  logic [CW-1:0] r_cnt;
  logic          r_move;
  logic          r_fire;
  logic          r_any;

  dir_t          w_dir_n;
  logic          w_act_n;
  logic          w_run_n;
  logic [CW-1:0] w_cnt_n;
  logic          w_mv_n;

  assign w_keys = {key_right_i, key_left_i,
                   key_down_i, key_up_i};

  for (genvar g = 0; g < 4; g++) begin : g_dir
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_db (
      .clk_run  (clk_run),
      .rst_n    (rst_n),
      .key_i    (w_keys[g]),
      .db_o     (w_db[g]),
      .db_rise_o(w_rise[g])
    );
  end

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
  ) u_fire (
    .clk_run  (clk_run),
    .rst_n    (rst_n),
    .key_i    (key_fire_i),
    .db_o     (w_fdb),
    .db_rise_o(w_frise)
  );

  always_comb begin
    w_dir_n = r_dir;
    w_act_n = r_act;
    if (|w_rise) begin
      w_dir_n = pick(w_rise);
      w_act_n = 1'b1;
    end else if (r_act && w_db[r_dir]) begin
      w_act_n = 1'b1;
    end else if (|w_db) begin
      w_dir_n = pick(w_db);
      w_act_n = 1'b1;
    end else begin
      w_act_n = 1'b0;
    end
  end

  // r_run marks that the strobe phase is live; any
  // idle, disable or direction change restarts it
  always_comb begin
    w_run_n = 1'b0;
    w_cnt_n = '0;
    w_mv_n  = 1'b0;
    if (en_i && w_act_n) begin
      w_run_n = 1'b1;
      if (!r_run || (w_dir_n != r_dir)) begin
        w_mv_n = 1'b1;
      end else if (r_cnt == LAST) begin
        w_mv_n = 1'b1;
      end else begin
        w_cnt_n = r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_run or negedge rst_n) begin
    if (!rst_n) begin
      r_dir  <= UP;
      r_act  <= 1'b0;
      r_run  <= 1'b0;
      r_cnt  <= '0;
      r_move <= 1'b0;
      r_fire <= 1'b0;
      r_any  <= 1'b0;
    end else begin
      r_dir  <= w_dir_n;
      r_act  <= w_act_n;
      r_run  <= w_run_n;
      r_cnt  <= w_cnt_n;
      r_move <= w_mv_n;
      r_fire <= en_i & w_frise;
      r_any  <= (|w_db) | w_fdb;
    end
  end

  assign direct_o  = r_dir;
  assign move_en_o = r_move;
  assign fire_o    = r_fire;
  assign any_key_o = r_any;

endmodule

// File: tb/tb_key_ctrl.sv
// tb_key_ctrl: directed checks of key_ctrl with
// DEBOUNCE_CYCLES=4 (MOVE_DIV=1 and a MOVE_DIV=4 copy).
module tb_key_ctrl;

  logic       clk_run = 1'b0;
  logic       rst_n   = 1'b0;
  logic       en_i    = 1'b1;
  logic       k_up    = 1'b1;
  logic       k_dn    = 1'b1;
  logic       k_lt    = 1'b1;
  logic       k_rt    = 1'b1;
  logic       k_fr    = 1'b1;
  logic [1:0] dir1, dir4;
  logic       mv1, mv4, fr1, fr4, any1, any4;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk_run = ~clk_run;

  key_ctrl #(
    .DEBOUNCE_CYCLES(4), .MOVE_DIV(1), .KEY_ACTIVE_LOW(1)
  ) dut (
    .clk_run(clk_run), .rst_n(rst_n), .en_i(en_i),
    .key_up_i(k_up), .key_down_i(k_dn),
    .key_left_i(k_lt), .key_right_i(k_rt),
    .key_fire_i(k_fr),
    .direct_o(dir1), .move_en_o(mv1),
    .fire_o(fr1), .any_key_o(any1)
  );

  key_ctrl #(
    .DEBOUNCE_CYCLES(4), .MOVE_DIV(4), .KEY_ACTIVE_LOW(1)
  ) dut4 (
    .clk_run(clk_run), .rst_n(rst_n), .en_i(en_i),
    .key_up_i(k_up), .key_down_i(k_dn),
    .key_left_i(k_lt), .key_right_i(k_rt),
    .key_fire_i(k_fr),
    .direct_o(dir4), .move_en_o(mv4),
    .fire_o(fr4), .any_key_o(any4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // n rising edges, then sample 1ns later
  task automatic edges(input int n);
    repeat (n) @(posedge clk_run);
    #1;
  endtask

  int pulses;

  initial begin
    edges(2);
    rst_n = 1'b1;
    chk("rst_dir", dir1, 2'b00);
    chk("rst_mv", mv1, 0);
    chk("rst_fire", fr1, 0);
    chk("rst_any", any1, 0);

    // single LEFT press: outputs move at edge 7
    k_lt = 1'b0;
    edges(7);
    chk("l_dir6", dir1, 2'b00);
    chk("l_mv6", mv1, 0);
    chk("l_any6", any1, 0);
    edges(1);
    chk("l_dir7", dir1, 2'b10);
    chk("l_mv7", mv1, 1);
    chk("l_any7", any1, 1);
    edges(3);
    chk("l_mv10", mv1, 1);
    k_lt = 1'b1;
    edges(10);
    chk("idle_dir", dir1, 2'b10);
    chk("idle_mv", mv1, 0);
    chk("idle_any", any1, 0);

    // 3-cycle glitch on UP must be ignored
    k_up = 1'b0;
    edges(3);
    k_up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      edges(1);
      chk("gl_any", any1, 0);
      chk("gl_mv", mv1, 0);
    end
    chk("gl_dir", dir1, 2'b10);

    // last pressed wins, fallback on release
    k_lt = 1'b0;
    edges(20);
    chk("lr_dir0", dir1, 2'b10);
    k_rt = 1'b0;
    edges(7);
    chk("lr_dir6", dir1, 2'b10);
    edges(1);
    chk("lr_dir7", dir1, 2'b11);
    chk("lr_mv7", mv1, 1);
    k_rt = 1'b1;
    edges(7);
    chk("rr_dir6", dir1, 2'b11);
    chk("rr_mv6", mv1, 1);
    edges(1);
    chk("rr_dir7", dir1, 2'b10);
    chk("rr_mv7", mv1, 1);
    k_lt = 1'b1;
    edges(10);
    chk("lr_idle", mv1, 0);

    // simultaneous UP+DOWN resolves to UP
    k_up = 1'b0;
    k_dn = 1'b0;
    edges(8);
    chk("ud_dir", dir1, 2'b00);
    chk("ud_mv", mv1, 1);
    k_up = 1'b1;
    edges(8);
    chk("ud_fall", dir1, 2'b01);
    k_dn = 1'b1;
    edges(10);
    chk("ud_idle", any1, 0);

    // MOVE_DIV=4: pulses at 7,11,15 then phase restart
    k_dn = 1'b0;
    edges(7);
    chk("d4_mv6", mv4, 0);
    for (int i = 0; i < 9; i++) begin
      edges(1);
      chk("d4_ph", mv4, (i % 4) == 0);
    end
    edges(1);
    k_lt = 1'b0;
    edges(6);
    // abs edges 23..28: old pulse 23, new phase 24, 28
    for (int i = 0; i < 6; i++) begin
      edges(1);
      chk("d4_sw", mv4, (i == 0 || i == 1 || i == 5));
    end
    chk("d4_dir", dir4, 2'b10);
    k_dn = 1'b1;
    k_lt = 1'b1;
    edges(10);
    chk("d4_idle", mv4, 0);

    // fire: one pulse per press, none while disabled
    k_fr = 1'b0;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      edges(1);
      if (fr1) pulses++;
    end
    chk("fire_one", pulses, 1);
    k_fr = 1'b1;
    edges(10);

    en_i = 1'b0;
    k_fr = 1'b0;
    k_rt = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      edges(1);
      if (fr1) pulses++;
      chk("dis_mv", mv1, 0);
    end
    chk("dis_fire", pulses, 0);
    chk("dis_dir", dir1, 2'b11);
    chk("dis_any", any1, 1);
    en_i = 1'b1;
    edges(1);
    chk("en_mv", mv1, 1);
    for (int i = 0; i < 20; i++) begin
      edges(1);
      if (fr1) pulses++;
    end
    chk("late_fire", pulses, 0);
    k_fr = 1'b1;
    edges(10);

    // async reset while RIGHT is active
    chk("pre_rst", dir1, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_dir", dir1, 2'b00);
    chk("ar_mv", mv1, 0);
    chk("ar_any", any1, 0);
    @(posedge clk_run);
    #1;
    rst_n = 1'b1;
    edges(7);
    chk("rr6_dir", dir1, 2'b00);
    chk("rr6_mv", mv1, 0);
    edges(1);
    chk("rr7_dir", dir1, 2'b11);
    chk("rr7_mv", mv1, 1);
    k_rt = 1'b1;
    edges(10);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
